vote_collector: RTL
===================

Name: vote_collector

Overview:
Front-end stage that gathers four raw "yes" buttons during a timed voting session and delivers a stable 4-bit vote vector to the 4-person voter/decoder, which turns it into reject/tie/pass.
- Synchronises and debounces each button.
- Latches each voter's press once per session.
- Closes the session on timeout or when all four voters have pressed.
- Holds the result with a valid/ack handshake until the downstream stage consumes it.

Parameters:
- N_VOTERS, 4, number of voters; fixed at 4 to match the downstream voter width.
- DEBOUNCE_CYCLES, 4, consecutive synchronised-high cycles required to recognise a press.
- WINDOW_CYCLES, 1000, maximum length of the COLLECT state in clock cycles.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start_i  input  1  opens a session; sampled only in IDLE.
- btn_i  input  4  raw asynchronous yes-buttons; bit n is voter n.
- ack_i  input  1  downstream has consumed votes_o.
- votes_o  output  4  latched vote vector; drives the voter's I input.
- valid_o  output  1  votes_o is final; high throughout HOLD.
- busy_o  output  1  high in COLLECT or HOLD.
- timeout_o  output  1  session closed by window expiry rather than by all four voting.

Behaviour:
- Reset (rst=1 at a clock edge): state IDLE, votes_o=0000, valid_o=0, busy_o=0, timeout_o=0, window counter 0, synchronisers and debounce counters 0.
  - Applies from any state, including mid-COLLECT and mid-HOLD.
- Input path, per bit:
  - 2-flop synchroniser, then a debounce counter.
  - Debounced level goes to 1 after DEBOUNCE_CYCLES consecutive synchronised-high cycles.
  - Debounced level returns to 0 on the first synchronised-low cycle.
  - A press is the rising edge of the debounced level.
  - Latency from btn_i rising to press pulse: 2 + DEBOUNCE_CYCLES cycles.
  - Debouncers run in all states.
- FSM states: IDLE, COLLECT, HOLD.
- IDLE:
  - start_i=1 -> COLLECT next cycle.
  - On that transition: votes_o cleared to 0000, window counter 0, timeout_o 0.
- COLLECT:
  - A press pulse on bit n sets votes_o[n]. Bits are sticky; releasing or re-pressing has no effect.
  - Window counter increments every cycle.
  - Next state is HOLD when either:
    - (a) counter == WINDOW_CYCLES-1; timeout_o set to 1, unless (b) also holds in that cycle;
    - (b) votes_o with this cycle's presses applied == 1111; timeout_o stays 0.
  - A press landing in the terminal-count cycle is still latched.
  - COLLECT lasts at most WINDOW_CYCLES cycles. Counter width is $clog2(WINDOW_CYCLES).
- HOLD:
  - valid_o=1; votes_o and timeout_o are frozen.
  - ack_i=1 -> IDLE next cycle; valid_o drops; votes_o keeps its value until the next session starts.
- Ignored inputs:
  - start_i outside IDLE, including the same cycle as ack_i in HOLD. start_i must be re-asserted once back in IDLE.
  - ack_i outside HOLD.
- Pre-held buttons: a button already debounced-high when COLLECT is entered produces no edge, so it is not counted until it is released and pressed again. A stuck button therefore cannot vote.
- busy_o = (state != IDLE); it is registered-state derived with no combinational input paths.
- All outputs are registered or decoded from state only.

Decomposition:
- Package vote_pkg:
  - state enum {IDLE, COLLECT, HOLD};
  - N_VOTERS=4;
  - result encodings shared with the voter: RES_REJECT=3'b100, RES_TIE=3'b010, RES_PASS=3'b001 (bench scoreboard uses these).
- Sub-module vote_debounce: one bit of synchroniser + debounce counter + rising-edge pulse, parameterised by DEBOUNCE_CYCLES. vote_collector instantiates it N_VOTERS times.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, WINDOW_CYCLES=64.
1. Reset: rst high 3 cycles, buttons toggling -> votes_o=0000, valid_o=0, busy_o=0, timeout_o=0 on every cycle with rst high.
2. Timeout close: start_i pulse; btn_i[0] and btn_i[2] held 10 cycles early in the window -> HOLD entered exactly 64 cycles after COLLECT entry; votes_o=0101, timeout_o=1, valid_o=1; voter output 010.
3. Early close: start_i pulse; all four buttons pressed within 20 cycles -> HOLD 1 cycle after the fourth press pulse, before count 64; votes_o=1111, timeout_o=0; voter output 001.
4. Glitch rejection: btn_i[1] high 3 cycles then low, during COLLECT -> no latch; after timeout votes_o=0000; voter output 100.
5. Pre-held button: btn_i[3] high before start_i and kept high -> votes_o[3]=0 at timeout. Repeat with release and re-press inside the window -> votes_o[3]=1.
6. Handshake and reset:
   - In HOLD, ack_i held low 20 cycles while start_i pulses -> valid_o stays 1 and votes_o is stable.
   - ack_i and start_i together -> IDLE, no new session.
   - rst mid-COLLECT -> IDLE next cycle with votes_o=0000.

Source files
------------

// File: rtl/vote_pkg.sv
// rtl/vote_pkg.sv - shared types and constants for the vote collector and its downstream voter
package vote_pkg;

    localparam int N_VOTERS = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    // Result encodings produced by the downstream 4-person voter
    localparam logic [2:0] RES_REJECT = 3'b100;
    localparam logic [2:0] RES_TIE    = 3'b010;
    localparam logic [2:0] RES_PASS   = 3'b001;

endpackage

// File: rtl/vote_debounce.sv
// rtl/vote_debounce.sv - one-bit synchroniser, debounce counter and press-edge pulse
module vote_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic [CW-1:0] cnt_q;
    logic          level_q;
    logic          press_q;

    // Two-flop synchroniser for the asynchronous button
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

    // Level rises after DEBOUNCE_CYCLES high samples, drops on the first low one; press marks the rise
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            press_q <= 1'b0;
            if (!sync2_q) begin
                cnt_q   <= '0;
                level_q <= 1'b0;
            end else if (!level_q) begin
                if (cnt_q == CNT_LAST) begin
                    level_q <= 1'b1;
                    press_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/vote_collector.sv
// rtl/vote_collector.sv - timed four-voter press collector with valid/ack result hold
module vote_collector
    import vote_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int WINDOW_CYCLES   = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [N_VOTERS-1:0] btn_i,
    input  logic                ack_i,
    output logic [N_VOTERS-1:0] votes_o,
    output logic                valid_o,
    output logic                busy_o,
    output logic                timeout_o
);

    localparam int WW = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW_CYCLES - 1);

    state_t              state_q;
    logic [N_VOTERS-1:0] votes_q;
    logic [N_VOTERS-1:0] votes_d;
    logic [N_VOTERS-1:0] press;
    logic [WW-1:0]       win_q;
    logic                valid_q;
    logic                timeout_q;

    for (genvar g = 0; g < N_VOTERS; g++) begin : g_db
        vote_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk    (clk),
            .rst    (rst),
            .btn_i  (btn_i[g]),
            .press_o(press[g])
        );
    end

    // Votes with this cycle's presses applied; bits are sticky within a session
    always_comb begin
        votes_d = votes_q | press;
    end

    // Session FSM: all-voted close has priority over window expiry in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            votes_q   <= '0;
            win_q     <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q   <= COLLECT;
                        votes_q   <= '0;
                        win_q     <= '0;
                        timeout_q <= 1'b0;
                    end
                end
                COLLECT: begin
                    votes_q <= votes_d;
                    win_q   <= win_q + WW'(1);
                    if (&votes_d) begin
                        state_q <= HOLD;
                        valid_q <= 1'b1;
                    end else if (win_q == WIN_LAST) begin
                        state_q   <= HOLD;
                        valid_q   <= 1'b1;
                        timeout_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (ack_i) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign votes_o   = votes_q;
    assign valid_o   = valid_q;
    assign timeout_o = timeout_q;
    assign busy_o    = (state_q != IDLE);

endmodule
